// File: rtl/alu_operand_loader_if.sv
// Operand loader bus: serial beat input on one side, A/B pair output on the other.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface alu_operand_loader_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pair_count;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_a, out_b, out_valid, pair_count
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_a, out_b, out_valid, pair_count
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects two serial beats (A then B) into an operand pair for the ALU bitwise stage.
// state_dbg encoding: 0 = EMPTY, 1 = HAVE_A, 2 = FULL.
module alu_operand_loader #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_loader_if.slave  bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready;
  logic             accept;
  logic             issue;

  assign bus.out_a      = a_q;
  assign bus.out_b      = b_q;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.pair_count = cnt_q;
  assign bus.in_ready   = in_ready;
  assign state_dbg      = state_q;

  // In FULL the slot frees up only when the pair leaves, so ready follows out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !bus.flush) begin
      case (state_q)
        EMPTY, HAVE_A: in_ready = 1'b1;
        FULL:          in_ready = bus.out_ready;
        default:       in_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && in_ready;
  assign issue  = (state_q == FULL) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    if (issue) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    case (state_q)
      EMPTY: begin
        if (accept) begin
          a_d     = bus.in_data;
          state_d = HAVE_A;
        end
      end
      HAVE_A: begin
        if (accept) begin
          b_d     = bus.in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (issue && accept) begin
          a_d     = bus.in_data;
          state_d = HAVE_A;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any held operand; accept is already blocked, operand regs keep their values.
    if (bus.flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus random traffic against a queue-based model.
module tb_alu_operand_loader;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  alu_operand_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: exp_q holds the beats of the current, not yet issued pair
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_a, m_b;
  logic [CNT_W-1:0] m_cnt;
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return rst_n && !bus.flush && (exp_q.size() < 2 || bus.out_ready);
  endfunction

  // driver: apply inputs, check at negedge, advance model on posedge
  task automatic cycle(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic fl);
    logic acc, iss;
    rst_n         = rst;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk);
    check("in_ready",   bus.in_ready,   model_ready());
    check("out_valid",  bus.out_valid,  exp_q.size() == 2);
    check("out_a",      bus.out_a,      m_a);
    check("out_b",      bus.out_b,      m_b);
    check("pair_count", bus.pair_count, m_cnt);
    acc = v && model_ready();
    iss = (exp_q.size() == 2) && ordy;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      m_a = '0; m_b = '0; m_cnt = '0;
    end else begin
      if (iss) begin
        m_cnt = m_cnt + 1'b1;
        exp_q.delete();
      end
      if (fl) begin
        exp_q.delete();
      end else if (acc) begin
        exp_q.push_back(d);
        if (exp_q.size() == 1) m_a = d;
        else                   m_b = d;
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b1, 1'b0, '0, ordy, 1'b0);
  endtask

  logic [CNT_W-1:0] cnt_save;

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_a = '0; m_b = '0; m_cnt = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Scenario 1: basic pair 3,5
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("s1_reset_state", state_dbg, 2'd0);
    check("s1_reset_cnt", bus.pair_count, 0);
    cycle(1'b1, 1'b1, 4'h3, 1'b1, 1'b0);
    check("s1_have_a", state_dbg, 2'd1);
    cycle(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
    check("s1_a", bus.out_a, 4'h3);
    check("s1_b", bus.out_b, 4'h5);
    check("s1_valid", bus.out_valid, 1'b1);
    check("s1_alu_xor", bus.out_a ^ bus.out_b, 4'h6);
    idle(1'b1);
    check("s1_valid_drop", bus.out_valid, 1'b0);
    check("s1_cnt", bus.pair_count, 1);

    // Scenario 2: back-pressure then issue with same-cycle A load
    cycle(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      check("s2_ready_low", bus.in_ready, 1'b0);
      check("s2_hold_a", bus.out_a, 4'hA);
      check("s2_hold_b", bus.out_b, 4'hF);
    end
    cycle(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
    check("s2_state", state_dbg, 2'd1);
    check("s2_new_a", bus.out_a, 4'h1);
    check("s2_b_kept", bus.out_b, 4'hF);
    check("s2_cnt", bus.pair_count, 2);

    // Scenario 3: flush a partial A
    idle(1'b0);
    cycle(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    cnt_save = bus.pair_count;
    cycle(1'b1, 1'b1, 4'h8, 1'b0, 1'b1);
    check("s3_flush_state", state_dbg, 2'd0);
    check("s3_flush_a_held", bus.out_a, 4'h9);
    cycle(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
    check("s3_a", bus.out_a, 4'h2);
    check("s3_b", bus.out_b, 4'h4);
    check("s3_cnt", bus.pair_count, cnt_save);

    // Scenario 5: reset while FULL
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("s5_a", bus.out_a, 0);
    check("s5_b", bus.out_b, 0);
    check("s5_valid", bus.out_valid, 0);
    check("s5_cnt", bus.pair_count, 0);
    cycle(1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
    check("s5_first_a", bus.out_a, 4'h7);
    check("s5_state", state_dbg, 2'd1);

    // Scenario 6: flush coincident with issue
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    cnt_save = bus.pair_count;
    rst_n = 1'b1; bus.in_valid = 1'b1; bus.in_data = 4'hE; bus.out_ready = 1'b1; bus.flush = 1'b1;
    #1;
    check("s6_ready_low", bus.in_ready, 1'b0);
    cycle(1'b1, 1'b1, 4'hE, 1'b1, 1'b1);
    check("s6_cnt", bus.pair_count, cnt_save + 1'b1);
    check("s6_state", state_dbg, 2'd0);
    check("s6_a_held", bus.out_a, 4'hC);

    // Scenario 4: 256 back-to-back pairs wrap the counter
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      cycle(1'b1, 1'b1, WIDTH'($urandom_range(0, 15)), 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    check("s4_wrap", bus.pair_count, 0);
    cycle(1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 4'h2, 1'b1, 1'b0);
    idle(1'b1);
    check("s4_after_wrap", bus.pair_count, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) != 0),
            WIDTH'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, as the operand width in bits, matching the ALU bitwise stage inputs.
REQ-002 The block SHALL have parameter CNT_W, default 8, as the width of the issued-pair counter.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_data  input  WIDTH  serial operand beat: the 1st beat of a pair is A, the 2nd is B.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a beat this cycle.
REQ-008 flush  input  1  synchronous abort of any partial or pending pair.
REQ-009 out_a  output  WIDTH  operand A to the ALU in1.
REQ-010 out_b  output  WIDTH  operand B to the ALU in2.
REQ-011 out_valid  output  1  the out_a/out_b pair is complete and stable.
REQ-012 out_ready  input  1  downstream consumes the pair.
REQ-013 pair_count  output  CNT_W  number of pairs issued.

Function
REQ-014 A beat SHALL be accepted iff in_valid=1 and in_ready=1 in the same cycle.
REQ-015 A pair SHALL be issued iff out_valid=1 and out_ready=1 in the same cycle.
REQ-016 The FSM SHALL have exactly three states:
- EMPTY: no operand held.
- HAVE_A: A held, B not yet received.
- FULL: pair held.
REQ-017 EMPTY: in_ready=1. An accepted beat SHALL load out_a and move to HAVE_A.
REQ-018 HAVE_A: in_ready=1. An accepted beat SHALL load out_b and move to FULL.
REQ-019 FULL: in_ready SHALL equal out_ready, combinationally.
REQ-020 FULL with issue and no accepted beat SHALL move to EMPTY.
REQ-021 FULL with issue and an accepted beat in the same cycle SHALL load the beat into out_a and move to HAVE_A; no bubble, no beat lost.
REQ-022 FULL without issue SHALL hold state, out_a and out_b.
REQ-023 out_valid SHALL be 1 exactly when the state is FULL; it SHALL be driven from state registers with no combinational path from in_valid.
REQ-024 out_a and out_b SHALL change only on the capture events above; out_b SHALL NOT change while in HAVE_A.
REQ-025 Latency SHALL be as follows:
- out_valid rises in the cycle after the accepting edge of the B beat.
- With out_ready held high, the issue rate is one pair per two accepted beats.
REQ-026 pair_count SHALL increment by 1 on each issue and wrap from 2^CNT_W-1 to 0 without saturating or flagging.
REQ-027 When flush=1:
- in_ready SHALL be forced to 0.
- The next state SHALL be EMPTY.
- out_a and out_b SHALL hold their values.
REQ-028 If an issue occurs in the same cycle as flush=1, that issue SHALL complete and be counted; any partial A SHALL be discarded.
REQ-029 flush SHALL NOT modify pair_count except through REQ-028.
REQ-030 in_valid during EMPTY or HAVE_A SHALL never be back-pressured unless flush=1.

Reset
REQ-031 While rst_n=0 at a rising clk edge, the block SHALL set:
- state to EMPTY;
- out_a, out_b and pair_count to 0;
- out_valid to 0.
REQ-032 While rst_n=0, in_ready SHALL be 0; reset SHALL take priority over flush and over all handshakes.
REQ-033 Reset asserted in HAVE_A or FULL SHALL discard the held operands; the first beat accepted after release SHALL be taken as A.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Scenario 1: reset, then beats 0x3, 0x5 with out_ready=1 -> out_a=0x3, out_b=0x5, out_valid high for 1 cycle, pair_count=1, ALU out=0x6.
- Scenario 2: out_ready=0 with pair 0xA,0xF held, then in_valid=1 with data 0x1 -> in_ready=0 and the pair is stable; after out_ready=1 the pair issues in the same cycle 0x1 loads as A, and the state is HAVE_A.
- Scenario 3: beat 0x9 (A only), then flush=1 -> EMPTY; the next beats 0x2, 0x4 give out_a=0x2, out_b=0x4, and pair_count is unchanged by the flush.
- Scenario 4: 256 back-to-back pairs with CNT_W=8 -> pair_count wraps to 0, then reads 1 after the 257th pair.
- Scenario 5: rst_n=0 held 1 cycle while FULL -> all outputs 0 the next cycle; the next beat 0x7 lands in out_a.
- Scenario 6: flush=1 coincident with an issue of pair 0xC,0x3 -> pair_count increments, the state is EMPTY, and in_ready=0 in that cycle.
